// File: rtl/mult_pkg.sv
//------------------------------------------------------------------------------
// mult_pkg: shared widths, FSM state type and carry-save helpers for the
// shared-multiplier datapath.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package mult_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } mult_state_t;

  // One 3:2 compressor layer applied across a full product-width row.
  function automatic logic [PROD_W-1:0] csa_sum(
    input logic [PROD_W-1:0] x,
    input logic [PROD_W-1:0] y,
    input logic [PROD_W-1:0] z
  );
    return x ^ y ^ z;
  endfunction

  function automatic logic [PROD_W-1:0] csa_carry(
    input logic [PROD_W-1:0] x,
    input logic [PROD_W-1:0] y,
    input logic [PROD_W-1:0] z
  );
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter: combinational round-robin arbiter; search starts at ptr and
// wraps, producing a one-hot grant plus its binary index.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  int              idx;
  logic [ID_W-1:0] sel;

  // Walk from the farthest offset down to ptr so the nearest requester wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = 0;
    sel    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      sel = ID_W'(idx);
      if (req[sel]) begin
        gnt      = '0;
        gnt[sel] = 1'b1;
        gnt_id   = sel;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wallace_tree.sv
//------------------------------------------------------------------------------
// wallace_tree: combinational 8x8 signed multiplier; sign-extended partial
// products reduced by carry-save layers and one final adder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module wallace_tree
  import mult_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  localparam int NUM_PP = OP_W + 1;

  logic [PROD_W-1:0] pp [NUM_PP];
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] row;

  // b's MSB carries weight -2^7, so that row is negated (~x, +1 in the last row).
  always_comb begin
    a_ext = {{(PROD_W - OP_W){a[OP_W-1]}}, a};
    row   = '0;
    for (int j = 0; j < OP_W; j++) begin
      row = b[j] ? (a_ext << j) : '0;
      pp[j] = (j == OP_W - 1) ? ~row : row;
    end
    pp[NUM_PP-1] = PROD_W'(1);
  end

  logic [PROD_W-1:0] s0, c0, s1, c1, s2, c2;
  logic [PROD_W-1:0] s3, c3, s4, c4;
  logic [PROD_W-1:0] s5, c5, s6, c6;

  // 9 -> 6 -> 4 -> 3 -> 2 rows.
  assign s0 = csa_sum  (pp[0], pp[1], pp[2]);
  assign c0 = csa_carry(pp[0], pp[1], pp[2]);
  assign s1 = csa_sum  (pp[3], pp[4], pp[5]);
  assign c1 = csa_carry(pp[3], pp[4], pp[5]);
  assign s2 = csa_sum  (pp[6], pp[7], pp[8]);
  assign c2 = csa_carry(pp[6], pp[7], pp[8]);

  assign s3 = csa_sum  (s0, c0, s1);
  assign c3 = csa_carry(s0, c0, s1);
  assign s4 = csa_sum  (c1, s2, c2);
  assign c4 = csa_carry(c1, s2, c2);

  assign s5 = csa_sum  (s3, c3, s4);
  assign c5 = csa_carry(s3, c3, s4);

  assign s6 = csa_sum  (s5, c5, c4);
  assign c6 = csa_carry(s5, c5, c4);

  assign p = s6 + c6;

endmodule

`default_nettype wire

// File: rtl/mult_share_arbiter.sv
//------------------------------------------------------------------------------
// mult_share_arbiter: round-robin sharing of one registered 8x8 signed
// multiplier between NUM_REQ requesters, with an ID-tagged response channel.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_a,
  input  logic [NUM_REQ*OP_W-1:0]   req_b,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [PROD_W-1:0]         resp_product,
  output logic                      busy
);

  mult_state_t       state, next_state;
  logic [ID_W-1:0]   rr_ptr, next_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_id;
  logic [OP_W-1:0]   a_q, b_q;
  logic [ID_W-1:0]   id_q;
  logic [PROD_W-1:0] core_p;
  logic              take;

  logic [OP_W-1:0] lane_a [NUM_REQ];
  logic [OP_W-1:0] lane_b [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_a[i] = req_a[i*OP_W +: OP_W];
    assign lane_b[i] = req_b[i*OP_W +: OP_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  wallace_tree u_core (
    .a (a_q),
    .b (b_q),
    .p (core_p)
  );

  assign take     = |req_ready;
  assign next_ptr = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (take) next_state = MUL;
      MUL:     next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic; grants are masked while reset is asserted.
  always_comb begin
    req_ready  = '0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!rst) req_ready = gnt;
      end
      MUL:     resp_valid = 1'b0;
      RESP:    resp_valid = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  // Operand capture on grant, product capture in MUL; held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      resp_id      <= '0;
      resp_product <= '0;
    end else begin
      if (state == IDLE && take) begin
        a_q    <= lane_a[gnt_id];
        b_q    <= lane_b[gnt_id];
        id_q   <= gnt_id;
        rr_ptr <= next_ptr;
      end
      if (state == MUL) begin
        resp_product <= core_p;
        resp_id      <= id_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
//------------------------------------------------------------------------------
// tb_mult_share_arbiter: vector table plus directed sequences; a monitor
// queues expected products at each grant and checks them at each response.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mult_share_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*8-1:0]  req_a;
  logic [N*8-1:0]  req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [1:0]      resp_id;
  logic [15:0]     resp_product;
  logic            busy;

  logic [7:0]  op_a     [N];
  logic [7:0]  op_b     [N];
  logic [15:0] exp_lane [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[g*8 +: 8] = op_a[g];
    assign req_b[g*8 +: 8] = op_b[g];
  end

  mult_share_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] prod;
    int          cyc;
  } sb_t;

  typedef struct {
    int          lane;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  sb_t  sb [$];
  int   grant_log [$];
  int   cycle    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_resp   = 0;
  logic prev_rv  = 1'b0;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: push expectation on grant, pop and compare on response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid && !prev_rv) begin
        if (sb.size() == 0) check("resp_without_request", 1, 0);
        else                check("resp_latency", cycle - sb[0].cyc, 2);
      end
      if (resp_valid && resp_ready) begin
        n_resp++;
        if (sb.size() == 0) begin
          check("spurious_resp", 1, 0);
        end else begin
          check("resp_id", resp_id, sb[0].id);
          check("resp_product", resp_product, sb[0].prod);
          void'(sb.pop_front());
        end
      end
      if (req_ready != '0) begin
        check("req_ready_onehot", $onehot(req_ready), 1);
        check("req_ready_without_valid", req_ready & ~req_valid, 0);
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) begin
            sb.push_back('{i, exp_lane[i], cycle});
            grant_log.push_back(i);
          end
        end
      end
      prev_rv = resp_valid;
    end else begin
      prev_rv = 1'b0;
    end
  end

  task automatic send(input int lane, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] e);
    int k = 0;
    @(posedge clk); #1;
    op_a[lane]      = a;
    op_b[lane]      = b;
    exp_lane[lane]  = e;
    req_valid[lane] = 1'b1;
    @(negedge clk);
    while (!req_ready[lane] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("grant_seen", req_ready[lane], 1);
    @(posedge clk); #1;
    req_valid[lane] = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int k = 0;
    while ((busy || sb.size() != 0) && k < max) begin
      @(negedge clk);
      k++;
    end
    check("drain", busy || (sb.size() != 0), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"},    req_ready,    0);
    check({tag, "_resp_valid"},   resp_valid,   0);
    check({tag, "_resp_id"},      resp_id,      0);
    check({tag, "_resp_product"}, resp_product, 0);
    check({tag, "_busy"},         busy,         0);
  endtask

  vec_t vecs [7];
  int   exp_order [5];

  initial begin
    int k;
    int r0;

    vecs[0] = '{2, 8'd7,    8'hFD, 16'hFFEB};  //  7 * -3
    vecs[1] = '{0, 8'h80,   8'h80, 16'h4000};  // -128 * -128
    vecs[2] = '{1, 8'h80,   8'h7F, 16'hC080};  // -128 * 127
    vecs[3] = '{3, 8'h7F,   8'h7F, 16'h3F01};  //  127 * 127
    vecs[4] = '{2, 8'd0,    8'hC9, 16'h0000};  //  0 * -55
    vecs[5] = '{1, 8'hFF,   8'hFF, 16'h0001};  // -1 * -1
    vecs[6] = '{3, 8'hF9,   8'd9,  16'hFFC1};  // -7 * 9
    exp_order = '{0, 1, 2, 3, 0};

    rst        = 1'b1;
    req_valid  = '1;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      op_a[i]     = 8'(i + 1);
      op_b[i]     = 8'd1;
      exp_lane[i] = '0;
    end

    // Reset state, with every lane requesting.
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single requests, including operand corners.
    foreach (vecs[v]) begin
      send(vecs[v].lane, vecs[v].a, vecs[v].b, vecs[v].exp);
      @(negedge clk);
      check("ready_one_cycle", req_ready, 0);
      check("mul_busy", busy, 1);
      check("mul_no_valid", resp_valid, 0);
      @(negedge clk);
      check("resp_valid_after_2", resp_valid, 1);
      wait_drain(20);
    end

    // Fairness from a fresh pointer.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      op_a[i]     = 8'(i + 1);
      op_b[i]     = 8'd10;
      exp_lane[i] = 16'((i + 1) * 10);
    end
    req_valid = '1;
    k = 0;
    while (grant_log.size() < 5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    req_valid = '0;
    check("fair_grant_count", grant_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (grant_log.size() > i) check("fair_order", grant_log[i], exp_order[i]);
    end
    wait_drain(40);

    // Back-pressure: response held, no grants while stalled.
    resp_ready = 1'b0;
    send(3, 8'd5, 8'hFA, 16'hFFE2);
    k = 0;
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp_resp_valid_seen", resp_valid, 1);
    @(posedge clk); #1;
    op_a[0] = 8'd2; op_b[0] = 8'd2; exp_lane[0] = 16'd4;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid",   resp_valid,   1);
      check("bp_product", resp_product, 16'hFFE2);
      check("bp_id",      resp_id,      3);
      check("bp_ready",   req_ready,    0);
      check("bp_busy",    busy,         1);
    end
    @(posedge clk); #1;
    resp_ready   = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_busy",  busy,       0);
    check("bp_idle_valid", resp_valid, 0);
    wait_drain(20);

    // Reset while in MUL; pointer was 3 beforehand.
    send(2, 8'd3, 8'd4, 16'd12);
    rst = 1'b1;
    op_a[0] = 8'd2; op_b[0] = 8'd2; exp_lane[0] = 16'd4;
    op_a[3] = 8'd3; op_b[3] = 8'd3; exp_lane[3] = 16'd9;
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    sb.delete();
    grant_log.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_release_idle", busy, 0);
    k = 0;
    while (grant_log.size() < 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    req_valid = '0;
    check("rst_grant_count", grant_log.size(), 2);
    if (grant_log.size() > 1) begin
      check("rst_first_lane0", grant_log[0], 0);
      check("rst_second_lane3", grant_log[1], 3);
    end
    wait_drain(40);

    // Withdrawn request while busy.
    grant_log.delete();
    r0 = n_resp;
    send(3, 8'h10, 8'h02, 16'h0020);
    op_a[1] = 8'd9; op_b[1] = 8'd9; exp_lane[1] = 16'hDEAD;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_drain(20);
    repeat (5) @(negedge clk);
    check("wd_grant_count", grant_log.size(), 1);
    if (grant_log.size() > 0) check("wd_only_lane3", grant_log[0], 3);
    check("wd_resp_count", n_resp - r0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
